// File: rtl/bob_retire_pkg.sv
// bob_retire_pkg: shared branch order buffer sizes and retire FSM encoding
package bob_retire_pkg;
   localparam int bob_addr_width = 6;
   localparam int bob_width = 64;
   localparam int bob_count = 48;
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FETCH = 2'd1,
      HEAD  = 2'd2
   } state_t;
endpackage

// File: rtl/bob_retire_upd_fifo.sv
// bob_upd_fifo: 2-deep first-word fall-through FIFO toward the predictor update pipe
module bob_upd_fifo
   import bob_retire_pkg::*;
#(
   parameter int DATA_WIDTH = bob_width
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_cnt
);
   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_cnt;
   assign o_data = r_mem[r_rd_ptr];
   assign o_cnt  = r_cnt;
   // pointers and occupancy; push+pop when full reuses the slot being read out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      end
   end
   // payload storage needs no reset; it is only observed when counted valid
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end
   a_cnt_max: assert property (@(posedge clk) disable iff (rst) r_cnt <= 2'd2);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && !i_pop && r_cnt == 2'd2));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && r_cnt == 2'd0));
endmodule

// File: rtl/bob_retire.sv
// bob_retire: in-order head fetch of the branch order buffer and retire handshake with the ROB
module bob_retire
   import bob_retire_pkg::*;
#(
   parameter int ADDR_WIDTH = bob_addr_width,
   parameter int DATA_WIDTH = bob_width,
   parameter int MISP_BIT   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  except,
   input  logic                  has_retire,
   input  logic [ADDR_WIDTH-1:0] retire_addr,
   output logic                  do_retire,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  br_retire,
   output logic                  br_retire_rdy,
   output logic                  upd_valid,
   input  logic                  upd_ready,
   output logic [DATA_WIDTH-1:0] upd_data,
   output logic                  upd_misp
);
   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_head;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [1:0]            w_cnt;
   logic                  w_pop;
   logic                  w_head_vld;
   assign upd_valid = w_cnt != 2'd0;
   assign upd_misp  = upd_data[MISP_BIT];
   // next state and handshake outputs; except and rst suppress every request
   always_comb begin
      w_head_vld    = r_state == HEAD;
      w_pop         = upd_valid && upd_ready;
      br_retire_rdy = w_head_vld && !except && !rst && (w_cnt < 2'd2 || w_pop);
      do_retire     = br_retire && br_retire_rdy;
      rd_en         = r_state == EMPTY && has_retire && !except && !rst;
      rd_addr       = rd_en ? retire_addr : r_rd_addr;
      w_next        = except ? EMPTY :
                      (r_state == EMPTY) ? (rd_en ? FETCH : EMPTY) :
                      (r_state == FETCH) ? HEAD :
                      (w_head_vld && !do_retire) ? HEAD : EMPTY;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else r_state <= w_next;
   end
   // head payload capture and last read address hold
   always_ff @(posedge clk) begin
      if (rst) r_rd_addr <= '0;
      else if (rd_en) r_rd_addr <= retire_addr;
      if (r_state == FETCH && !except) r_head <= rd_data;
   end
   bob_upd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .i_push(do_retire),
      .i_pop (w_pop),
      .i_data(r_head),
      .o_data(upd_data),
      .o_cnt (w_cnt)
   );
   a_retire_head: assert property (@(posedge clk) disable iff (rst) do_retire |-> w_head_vld);
   a_retire_bob: assert property (@(posedge clk) disable iff (rst) do_retire |-> has_retire);
endmodule
